// File: rtl/quadra_pkg.sv
// rtl/quadra_pkg.sv - shared quadratic-approximation definitions (squarer widths, rounding mode)
package quadra_pkg;

    // Per-sample rounding mode carried down the squarer pipeline.
    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    // Default squarer widths for the x2 path.
    localparam int SQP_IN_W  = 17;
    localparam int SQP_OUT_W = 17;

    // Width of a square: a signed operand loses one redundant sign bit.
    function automatic int pw(input int in_w, input int signed_);
        return 2 * in_w - signed_;
    endfunction

endpackage

// File: rtl/squarer_pipe_reg.sv
// rtl/squarer_pipe_reg.sv - one valid/data pipeline register with load enable
module squarer_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid,
    output logic [W-1:0] data
);

    // Load valid and data together whenever this slot may advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (en) begin
            valid <= valid_in;
            data  <= data_in;
        end
    end

endmodule

// File: rtl/squarer_pipe.sv
// rtl/squarer_pipe.sv - pipelined fixed-point squarer with valid/ready flow control
module squarer_pipe
    import quadra_pkg::*;
#(
    parameter  int IN_W   = SQP_IN_W,
    parameter  int OUT_W  = SQP_OUT_W,
    parameter  int SIGNED = 0,
    parameter  int STAGES = 2,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PW   = pw(IN_W, SIGNED);
    localparam int DROP = PW - OUT_W;
    // Intermediate stages carry the full product plus its rounding mode bit.
    localparam int DW   = PW + 1;
    localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic              in_xfer;
    logic              out_xfer;

    logic [2*IN_W-1:0] x_ext;
    logic [2*IN_W-1:0] full;
    logic [DW-1:0]     head;
    logic [DW-1:0]     tail_src;
    logic [OUT_W-1:0]  rounded;
    logic [DW-1:0]     mid_q [NMID];
    logic              unused_bits;

    // Extend to the product width so a plain modular multiply gives the
    // correct low bits for both signed and unsigned operands.
    if (SIGNED != 0) begin : g_sext
        assign x_ext = {{IN_W{in_data[IN_W-1]}}, in_data};
    end else begin : g_zext
        assign x_ext = {{IN_W{1'b0}}, in_data};
    end

    assign full = x_ext * x_ext;
    assign head = {in_rnd, full[PW-1:0]};

    // Rounding happens on whatever feeds the final stage.
    if (STAGES == 1) begin : g_tail_direct
        assign tail_src = head;
        assign mid_q[0] = '0;
    end else begin : g_tail_piped
        assign tail_src = mid_q[STAGES-2];
    end

    // Half-up adds the first dropped bit; the square never carries out.
    if (DROP > 0) begin : g_round
        logic half_up;
        assign half_up = (rnd_mode_e'(tail_src[PW]) == RND_HALF_UP) && tail_src[DROP-1];
        assign rounded = tail_src[PW-1 -: OUT_W] + OUT_W'(half_up);
    end else begin : g_noround
        assign rounded = tail_src[PW-1:0];
    end

    // Low product bits and the spare sign bit only matter for rounding.
    assign unused_bits = ^{full, tail_src, mid_q[0]};

    // Ready ripples back from the output: a slot may load if it is empty
    // or its contents move on this cycle, so bubbles collapse.
    always_comb begin : p_enable
        logic ripple;
        ripple = out_ready;
        en     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ripple = !v[k] || ripple;
            en[k]  = ripple;
        end
    end

    assign in_ready  = en[0] & !rst;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v[STAGES-1];
    assign out_xfer  = out_valid & out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic vin;

        if (k == 0) begin : g_vin_first
            assign vin = in_xfer;
        end else begin : g_vin_chain
            assign vin = v[k-1];
        end

        if (k == STAGES - 1) begin : g_last
            squarer_pipe_reg #(
                .W (OUT_W)
            ) u_reg (
                .clk      (clk),
                .rst      (rst),
                .en       (en[k]),
                .valid_in (vin),
                .data_in  (rounded),
                .valid    (v[k]),
                .data     (out_data)
            );
        end else begin : g_mid
            logic [DW-1:0] din;

            if (k == 0) begin : g_din_first
                assign din = head;
            end else begin : g_din_chain
                assign din = mid_q[k-1];
            end

            squarer_pipe_reg #(
                .W (DW)
            ) u_reg (
                .clk      (clk),
                .rst      (rst),
                .en       (en[k]),
                .valid_in (vin),
                .data_in  (din),
                .valid    (v[k]),
                .data     (mid_q[k])
            );
        end
    end

    // Occupancy tracks samples accepted but not yet delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule
